sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, with the same write/read enable and full/empty flag style.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer blocks in the same clock domain. Its ports match the fields of the existing FIFO interface, so the current UVM agents can drive it.

Parameters:
- width, 16, data word width in bits (≥1).
- depth, 16, number of entries; power of two, ≥2.
- afull_th, depth-2, almost_full asserts when count ≥ afull_th (1..depth).
- aempty_th, 2, almost_empty asserts when count ≤ aempty_th (0..depth-1).
- fwft, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- w_en  input  1  write request.
- w_data  input  width  write data.
- r_en  input  1  read request.
- r_data  output  width  read data.
- full_flag  output  1  count == depth.
- empty_flag  output  1  count == 0.
- almost_full  output  1  count ≥ afull_th.
- almost_empty  output  1  count ≤ aempty_th.
- count  output  $clog2(depth)+1  current occupancy, 0..depth.
- overflow  output  1  sticky: a write was rejected while full.
- underflow  output  1  sticky: a read was rejected while empty.
- clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rstn low, asynchronous):
  - Pointers, count, r_data, overflow and underflow go to 0.
  - empty_flag=1, almost_empty=1, full_flag=0, almost_full=0.
  - Storage array is not reset.
  - Release is synchronous to clk; the first accepted operation is on the first edge with rstn high.
- Accept rules:
  - Write is accepted iff w_en && !full_flag.
  - Read is accepted iff r_en && !empty_flag.
  - Flags are sampled as registered at the edge.
- Simultaneous events:
  - Read and write both accepted: count unchanged, both pointers advance.
  - Both requested at full: read only; write is rejected and sets overflow.
  - Both requested at empty: write only; read is rejected and sets underflow.
- Pointers:
  - $clog2(depth)+1 bits; the MSB is the wrap bit.
  - Storage index = pointer[$clog2(depth)-1:0].
  - Wrap from depth-1 to 0 is natural binary roll-over.
- count:
  - Registered; +1 on write-only, −1 on read-only.
  - Never exceeds depth and never goes below 0.
- Flags:
  - All flags are registered and decoded from the next-state count, so they are valid in the same cycle as the new count.
  - No combinational path exists from w_en/r_en to any flag.
- Read mode fwft=0:
  - r_data is registered.
  - The word read at edge N appears after edge N (one-cycle latency) and holds until the next accepted read.
- Read mode fwft=1:
  - r_data always shows the head entry when empty_flag=0.
  - An accepted r_en pops the entry; the next entry is visible after that edge.
  - Write into an empty FIFO: the word is visible on r_data one cycle after the write edge, together with empty_flag falling.
  - When empty, r_data holds its last value.
- overflow/underflow:
  - Set on the cycle after the rejection and held until clr_err.
  - clr_err in the same cycle as a new rejection: set wins.
- Data order is strict FIFO; no data is lost or duplicated across pointer wrap.
- Rejected operations change no pointer, count or data.

Test Plan:
- Reset, then write 16 words 0x0001..0x0010 (depth=16), then read 16: read order matches, no lost words.
  - Fill: count steps 1..16; almost_full rises when count reaches 14; full_flag=1 at 16.
  - Drain: r_data = 0x0001..0x0010 in order; almost_empty rises when count falls to 2; empty_flag=1 at 0.
- At full, assert w_en+r_en for 1 cycle with w_data=0xBEEF: read accepted, write rejected, count=15, overflow=1. Then pulse clr_err: overflow=0.
- At empty, pulse r_en: count stays 0, underflow=1, r_data unchanged. Then clr_err together with another empty read: underflow stays 1.
- With count=8, run 40 cycles of simultaneous w_en+r_en carrying an incrementing sequence: count stays 8, pointers wrap twice, output sequence lags input by exactly 8 words.
- Reset mid-operation: with count=10, drop rstn for a partial cycle (between edges). Immediately count=0, empty_flag=1, flags at reset values. After release, write 0x00AA then read: returns 0x00AA, not stale data.
- fwft=1: write 0x1234 into empty FIFO. Next cycle empty_flag=0 and r_data=0x1234 with no r_en. Pulse r_en: empty_flag=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// sync_fifo_ctrl_if
//   Handshake bundle between a single-clock FIFO controller and its
//   producer/consumer. Field names match the existing FIFO interface so the
//   current agents can drive it.
//   master : producer/consumer side (drives w_en, w_data, r_en, clr_err)
//   slave  : FIFO side (drives read data, occupancy, flags, sticky errors)
interface sync_fifo_ctrl_if #(
  parameter int width = 16,
  parameter int depth = 16
);
  localparam int cw = $clog2(depth) + 1;

  logic             w_en;
  logic [width-1:0] w_data;
  logic             r_en;
  logic [width-1:0] r_data;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic [cw-1:0]    count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  modport master (
    output w_en, w_data, r_en, clr_err,
    input  r_data, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, w_data, r_en, clr_err,
    output r_data, full_flag, empty_flag, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
//   Single-clock FIFO controller with occupancy count, almost-full /
//   almost-empty thresholds, sticky overflow/underflow flags and a selectable
//   first-word-fall-through read mode.
// Ports
//   clk   : single clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : sync_fifo_ctrl_if.slave
//           in : w_en, w_data, r_en, clr_err
//           out: r_data, full_flag, empty_flag, almost_full, almost_empty,
//                count, overflow, underflow
// Parameters
//   width     : data word width
//   depth     : entries, power of two >= 2
//   afull_th  : almost_full when count >= afull_th
//   aempty_th : almost_empty when count <= aempty_th
//   fwft      : 0 = registered read, 1 = first-word-fall-through
module sync_fifo_ctrl #(
  parameter int width     = 16,
  parameter int depth     = 16,
  parameter int afull_th  = depth - 2,
  parameter int aempty_th = 2,
  parameter bit fwft      = 1'b0
) (
  input logic             clk,
  input logic             rstn,
  sync_fifo_ctrl_if.slave bus
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;

  // storage and registered state
  logic [width-1:0] mem_r [depth];
  logic [cw-1:0]    wr_ptr_r;
  logic [cw-1:0]    rd_ptr_r;
  logic [cw-1:0]    count_r;
  logic [width-1:0] r_data_r;
  logic             full_r;
  logic             empty_r;
  logic             afull_r;
  logic             aempty_r;
  logic             ovf_r;
  logic             unf_r;

  // next-state terms
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             wr_rej_s;
  logic             rd_rej_s;
  logic [cw-1:0]    wr_ptr_nxt_s;
  logic [cw-1:0]    rd_ptr_nxt_s;
  logic [cw-1:0]    count_nxt_s;
  logic [width-1:0] head_nxt_s;
  logic [width-1:0] r_data_nxt_s;
  logic             full_nxt_s;
  logic             empty_nxt_s;
  logic             afull_nxt_s;
  logic             aempty_nxt_s;
  logic             ovf_nxt_s;
  logic             unf_nxt_s;

  // Accept/reject decisions use only the registered flags, so no request
  // input ever reaches a flag combinationally.
  always_comb begin
    wr_acc_s = bus.w_en && !full_r;
    rd_acc_s = bus.r_en && !empty_r;
    wr_rej_s = bus.w_en && full_r;
    rd_rej_s = bus.r_en && empty_r;
  end

  // Pointer and occupancy next state; simultaneous accept leaves count alone.
  always_comb begin
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + cw'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + cw'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + cw'(1);
      2'b01:   count_nxt_s = count_r - cw'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Flags are decoded from the next count so they line up with the new count.
  always_comb begin
    full_nxt_s   = (count_nxt_s == cw'(depth));
    empty_nxt_s  = (count_nxt_s == cw'(0));
    afull_nxt_s  = (count_nxt_s >= cw'(afull_th));
    aempty_nxt_s = (count_nxt_s <= cw'(aempty_th));
  end

  // Sticky error flags: a fresh rejection beats a simultaneous clear.
  always_comb begin
    if (wr_rej_s) begin
      ovf_nxt_s = 1'b1;
    end else if (bus.clr_err) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    if (rd_rej_s) begin
      unf_nxt_s = 1'b1;
    end else if (bus.clr_err) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // Head entry after this edge. When the new head is the very slot being
  // written this cycle (write into empty, or read+write at count 1), the
  // word is not in storage yet, so it is bypassed from w_data.
  always_comb begin
    if (wr_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = bus.w_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[aw-1:0]];
    end
  end

  // Read data next state for the selected read mode.
  always_comb begin
    r_data_nxt_s = r_data_r;
    if (fwft) begin
      // hold last value once the FIFO drains
      if (count_nxt_s != cw'(0)) begin
        r_data_nxt_s = head_nxt_s;
      end else begin
        r_data_nxt_s = r_data_r;
      end
    end else begin
      // registered read: capture the popped word, hold otherwise
      if (rd_acc_s) begin
        r_data_nxt_s = mem_r[rd_ptr_r[aw-1:0]];
      end else begin
        r_data_nxt_s = r_data_r;
      end
    end
  end

  // Storage write port; the array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[aw-1:0]] <= bus.w_data;
    end
  end

  // Control state, flags and read data register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      r_data_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      r_data_r <= r_data_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      afull_r  <= afull_nxt_s;
      aempty_r <= aempty_nxt_s;
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
    end
  end

  assign bus.r_data       = r_data_r;
  assign bus.full_flag    = full_r;
  assign bus.empty_flag   = empty_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.count        = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one registered-read and one FWFT instance share
// the same stimulus and are compared against a queue-based reference model,
// a table of hand-derived vectors, and directed corner-case sequences.
module tb_sync_fifo_ctrl;

  localparam int W = 16;
  localparam int D = 16;

  logic clk;
  logic rstn;

  sync_fifo_ctrl_if #(.width(W), .depth(D)) bus0 ();
  sync_fifo_ctrl_if #(.width(W), .depth(D)) bus1 ();

  sync_fifo_ctrl #(.width(W), .depth(D), .afull_th(D - 2), .aempty_th(2), .fwft(1'b0))
    dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  sync_fifo_ctrl #(.width(W), .depth(D), .afull_th(D - 2), .aempty_th(2), .fwft(1'b1))
    dut1 (.clk(clk), .rstn(rstn), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0] mq [$];
  bit           m_ovf;
  bit           m_unf;
  logic [W-1:0] m_rd0;
  logic [W-1:0] m_rd1;

  typedef struct {
    bit           w;
    logic [W-1:0] d;
    bit           r;
    bit           c;
    int           cnt;
    bit           emp;
    bit           ful;
    bit           af;
    bit           ae;
    bit           ovf;
    bit           unf;
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
  } vec_t;

  vec_t tv [12];

  function automatic vec_t mk(bit w, logic [W-1:0] d, bit r, bit c, int cnt,
                              bit emp, bit ful, bit af, bit ae, bit ovf, bit unf,
                              logic [W-1:0] rd0, logic [W-1:0] rd1);
    vec_t v;
    v.w = w; v.d = d; v.r = r; v.c = c; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
    v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd0 = '0;
    m_rd1 = '0;
  endtask

  task automatic set_in(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bus0.w_en = w; bus0.w_data = d; bus0.r_en = r; bus0.clr_err = c;
    bus1.w_en = w; bus1.w_data = d; bus1.r_en = r; bus1.clr_err = c;
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("m_cnt0",  bus0.count,        n);
    chk("m_cnt1",  bus1.count,        n);
    chk("m_full0", bus0.full_flag,    (n == D));
    chk("m_full1", bus1.full_flag,    (n == D));
    chk("m_emp0",  bus0.empty_flag,   (n == 0));
    chk("m_emp1",  bus1.empty_flag,   (n == 0));
    chk("m_af0",   bus0.almost_full,  (n >= D - 2));
    chk("m_af1",   bus1.almost_full,  (n >= D - 2));
    chk("m_ae0",   bus0.almost_empty, (n <= 2));
    chk("m_ae1",   bus1.almost_empty, (n <= 2));
    chk("m_ovf0",  bus0.overflow,     m_ovf);
    chk("m_ovf1",  bus1.overflow,     m_ovf);
    chk("m_unf0",  bus0.underflow,    m_unf);
    chk("m_unf1",  bus1.underflow,    m_unf);
    chk("m_rd0",   bus0.r_data,       m_rd0);
    chk("m_rd1",   bus1.r_data,       m_rd1);
  endtask

  // One clock: drive, let the edge happen, advance the model, check at negedge.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c);
    bit mfull;
    bit mempty;
    set_in(w, d, r, c);
    @(posedge clk);
    mfull  = (mq.size() == D);
    mempty = (mq.size() == 0);
    if (w && mfull) m_ovf = 1'b1;
    else if (c)     m_ovf = 1'b0;
    if (r && mempty) m_unf = 1'b1;
    else if (c)      m_unf = 1'b0;
    if (r && !mempty) m_rd0 = mq.pop_front();
    if (w && !mfull)  mq.push_back(d);
    if (mq.size() > 0) m_rd1 = mq[0];
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int wp;
    logic [W-1:0] held;

    // Hand-derived vectors, applied straight out of reset.
    tv[0]  = mk(1'b1, 16'h0011, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0011);
    tv[1]  = mk(1'b1, 16'h0022, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0011);
    tv[2]  = mk(1'b1, 16'h0033, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0011);
    tv[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0022);
    tv[4]  = mk(1'b1, 16'h0044, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0022, 16'h0033);
    tv[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0033, 16'h0044);
    tv[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0044);
    tv[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0044, 16'h0044);
    tv[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0044);
    tv[9]  = mk(1'b1, 16'h0055, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0044, 16'h0055);
    tv[10] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 16'h0055);
    tv[11] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0055, 16'h0055);

    // reset
    rstn = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt",   bus0.count,        0);
    chk("rst_empty", bus0.empty_flag,   1);
    chk("rst_ae",    bus0.almost_empty, 1);
    chk("rst_full",  bus0.full_flag,    0);
    chk("rst_af",    bus0.almost_full,  0);
    chk("rst_rd",    bus0.r_data,       0);
    check_model();
    rstn = 1'b1;

    // table vectors
    for (int i = 0; i < 12; i++) begin
      step(tv[i].w, tv[i].d, tv[i].r, tv[i].c);
      chk($sformatf("tv%0d_cnt", i), bus0.count,        tv[i].cnt);
      chk($sformatf("tv%0d_emp", i), bus0.empty_flag,   tv[i].emp);
      chk($sformatf("tv%0d_ful", i), bus0.full_flag,    tv[i].ful);
      chk($sformatf("tv%0d_af", i),  bus0.almost_full,  tv[i].af);
      chk($sformatf("tv%0d_ae", i),  bus0.almost_empty, tv[i].ae);
      chk($sformatf("tv%0d_ovf", i), bus0.overflow,     tv[i].ovf);
      chk($sformatf("tv%0d_unf", i), bus0.underflow,    tv[i].unf);
      chk($sformatf("tv%0d_rd0", i), bus0.r_data,       tv[i].rd0);
      chk($sformatf("tv%0d_rd1", i), bus1.r_data,       tv[i].rd1);
    end

    // fill 1..16 then drain in order
    for (int i = 1; i <= D; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      chk("fill_cnt",  bus0.count,       i);
      chk("fill_af",   bus0.almost_full, (i >= 14));
      chk("fill_full", bus0.full_flag,   (i == D));
    end
    for (int i = 1; i <= D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("drain_rd",  bus0.r_data,       i);
      chk("drain_cnt", bus0.count,        D - i);
      chk("drain_ae",  bus0.almost_empty, ((D - i) <= 2));
      chk("drain_emp", bus0.empty_flag,   (i == D));
    end

    // overflow at full with read+write, then clear
    for (int i = 1; i <= D; i++) step(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("ovf_cnt", bus0.count,    15);
    chk("ovf_set", bus0.overflow, 1);
    chk("ovf_rd",  bus0.r_data,   16'h0101);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", bus0.overflow, 0);
    for (int i = 2; i <= D; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk("ovf_drain", bus0.r_data, 16'h0100 + i);
    end

    // underflow at empty; clear loses to a simultaneous rejection
    held = bus0.r_data;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("unf_cnt",  bus0.count,     0);
    chk("unf_set",  bus0.underflow, 1);
    chk("unf_rd",   bus0.r_data,    held);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("unf_win",  bus0.underflow, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("unf_clr",  bus0.underflow, 0);

    // steady state at count 8 across pointer wraps
    for (int i = 0; i < 8; i++) step(1'b1, W'(16'h1000 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step(1'b1, W'(16'h1008 + k), 1'b1, 1'b0);
      chk("lag_cnt", bus0.count,  8);
      chk("lag_rd",  bus0.r_data, 16'h1000 + k);
    end

    // asynchronous reset between edges at count 10
    step(1'b1, 16'h2000, 1'b0, 1'b0);
    step(1'b1, 16'h2001, 1'b0, 1'b0);
    chk("pre_rst_cnt", bus0.count, 10);
    #1 rstn = 1'b0;
    #1;
    chk("arst_cnt0",  bus0.count,        0);
    chk("arst_cnt1",  bus1.count,        0);
    chk("arst_emp",   bus0.empty_flag,   1);
    chk("arst_ae",    bus0.almost_empty, 1);
    chk("arst_af",    bus0.almost_full,  0);
    chk("arst_full",  bus0.full_flag,    0);
    #1 rstn = 1'b1;
    model_reset();
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("arst_rd", bus0.r_data, 16'h00AA);

    // first-word-fall-through into an empty FIFO
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("fwft_emp", bus1.empty_flag, 0);
    chk("fwft_rd",  bus1.r_data,     16'h1234);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("fwft_hold", bus1.r_data,    16'h1234);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fwft_pop", bus1.empty_flag, 1);
    chk("fwft_last", bus1.r_data,    16'h1234);

    // randomized traffic against the model, alternating fill/drain bias
    wp = 70;
    for (int n = 0; n < 3000; n++) begin
      if ((n % 200) == 0) wp = (wp == 70) ? 30 : 70;
      step(($urandom_range(0, 99) < wp), W'($urandom), ($urandom_range(0, 99) < (100 - wp)),
           ($urandom_range(0, 99) < 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
